// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider with overflow and divide-by-zero flags
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             ofFlag,
  output logic             dbzFlag
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] q_mag, d_mag, dvd, rem, q_fix, r_fix;
  logic [WIDTH:0] shifted, trial;
  logic [CW-1:0] cnt;
  logic sign_a, sign_b, dbz, ovf, accept, zero_div;
  assign accept = state == IDLE && start;
  assign zero_div = divisor == '0;
  assign busy = state != IDLE;
  assign shifted = {rem, q_mag[WIDTH-1]};
  assign trial = shifted - {1'b0, d_mag};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    q_fix = (sign_a ^ sign_b) ? -q_mag : q_mag;
    r_fix = sign_a ? -rem : rem;
    state_nx = accept ? (zero_div ? FIX : CALC)
             : state == CALC ? (cnt == CW'(1) ? FIX : CALC)
             : state == FIX ? IDLE : state;
  end
  // The partial remainder stays below the divisor magnitude, so WIDTH bits hold it between steps
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q_mag <= '0;
      d_mag <= '0;
      dvd <= '0;
      rem <= '0;
      cnt <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dbz <= 1'b0;
      ovf <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      done <= 1'b0;
      ofFlag <= 1'b0;
      dbzFlag <= 1'b0;
    end else begin
      done <= state == FIX;
      if (accept) begin
        dvd <= dividend;
        sign_a <= dividend[WIDTH-1];
        sign_b <= divisor[WIDTH-1];
        q_mag <= dividend[WIDTH-1] ? -dividend : dividend;
        d_mag <= divisor[WIDTH-1] ? -divisor : divisor;
        rem <= '0;
        cnt <= CW'(WIDTH);
        dbz <= zero_div;
        ovf <= dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
      end
      if (state == CALC) begin
        rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_mag <= {q_mag[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt - CW'(1);
      end
      if (state == FIX) begin
        quotient <= dbz ? '0 : q_fix;
        remainder <= dbz ? dvd : r_fix;
        dbzFlag <= dbz;
        ofFlag <= ovf && !dbz;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed scoreboard bench for the signed sequential divider
module tb_seq_divider;
  logic clk, reset, start, busy, done, ofFlag, dbzFlag;
  logic [7:0] dividend, divisor, quotient, remainder;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic of;
    logic dbz;
    int lat;
    int t0;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0;
  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor), .start(start),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .ofFlag(ofFlag), .dbzFlag(dbzFlag)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(logic [7:0] a, logic [7:0] b);
    exp_t e;
    int sa, sb2;
    sa = $signed(a);
    sb2 = $signed(b);
    e.t0 = 0;
    e.of = 1'b0;
    e.dbz = 1'b0;
    e.lat = 9;
    if (b == 8'd0) begin
      e.q = 8'd0;
      e.r = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else if (sa == -128 && sb2 == -1) begin
      e.q = 8'h80;
      e.r = 8'd0;
      e.of = 1'b1;
    end else begin
      e.q = 8'(sa / sb2);
      e.r = 8'(sa % sb2);
    end
    return e;
  endfunction
  task automatic push(logic [7:0] a, logic [7:0] b);
    exp_t e;
    e = model(a, b);
    e.t0 = cyc;
    sb.push_back(e);
  endtask
  task automatic start_op(logic [7:0] a, logic [7:0] b);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push(a, b);
  endtask
  task automatic expect_done(string tag);
    exp_t e;
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, busy, 1);
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, done, 1);
    e = sb.pop_front();
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_latency"}, cyc - e.t0, e.lat);
    chk({tag, "_quotient"}, quotient, e.q);
    chk({tag, "_remainder"}, remainder, e.r);
    chk({tag, "_ofFlag"}, ofFlag, e.of);
    chk({tag, "_dbzFlag"}, dbzFlag, e.dbz);
  endtask
  task automatic done_drops(string tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {quotient, remainder, busy, done, ofFlag, dbzFlag}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_quotient", quotient, 0);
    chk("mid_rst_remainder", remainder, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("after_rst_idle", {busy, done}, 0);
    start_op(8'd9, 8'd3);
    expect_done("d9_3");
    done_drops("d9_3");
    start_op(8'd100, 8'd7);
    expect_done("d100_7");
    done_drops("d100_7");
    start_op(-8'sd100, 8'd7);
    expect_done("dm100_7");
    done_drops("dm100_7");
    start_op(8'd7, -8'sd100);
    expect_done("d7_m100");
    done_drops("d7_m100");
    start_op(-8'sd8, -8'sd2);
    expect_done("dm8_m2");
    done_drops("dm8_m2");
    start_op(8'h80, 8'hFF);
    expect_done("ovf");
    done_drops("ovf");
    chk("ovf_hold", ofFlag, 1);
    start_op(8'h80, 8'd1);
    expect_done("dm128_1");
    done_drops("dm128_1");
    start_op(8'd5, 8'd0);
    expect_done("dbz");
    done_drops("dbz");
    chk("dbz_hold", {dbzFlag, remainder}, {1'b1, 8'd5});
    start_op(8'd10, 8'd3);
    expect_done("d10_3");
    done_drops("d10_3");
    start_op(8'd127, 8'd2);
    repeat (2) @(posedge clk);
    #1;
    dividend = 8'd1;
    divisor = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    expect_done("ign_start");
    done_drops("ign_start");
    start_op(8'd50, 8'd5);
    dividend = 8'd20;
    divisor = 8'd6;
    start = 1'b1;
    expect_done("b2b_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    push(8'd20, 8'd6);
    chk("b2b_done_pulse", done, 0);
    chk("b2b_accepted", busy, 1);
    expect_done("b2b_second");
    done_drops("b2b_second");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
